// File: rtl/txsw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : txsw_pkg
// Purpose  : Shared serve-FSM state type and round-robin pick helper for txreq_arbsw.
// Revision : 1.0 - initial release
// ============================================================================
package txsw_pkg;

  localparam int MAX_CLIENTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } srv_state_e;

  // Index of the first set bit of elig scanning upward (with wrap) from start; -1 if none.
  function automatic int rr_pick(input logic [MAX_CLIENTS-1:0] elig,
                                 input int start, input int n);
    int         win;
    int         idx;
    logic [2:0] idx3;
    win = -1;
    for (int k = 0; k < MAX_CLIENTS; k++) begin
      idx  = (start + k) % n;
      idx3 = idx[2:0];
      if (win < 0 && k < n && elig[idx3]) begin
        win = idx;
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/txreq_arbsw_if.sv
`default_nettype none
// ============================================================================
// Module   : txreq_arbsw_if
// Purpose  : Client request / downstream tx bundle for the transmit-request switch.
// Revision : 1.0 - initial release
// ============================================================================
interface txreq_arbsw_if #(
  parameter int NCLIENT = 4,
  parameter int CW      = 16,
  parameter int DW      = 8,
  parameter int AW      = 5
);
  logic [NCLIENT-1:0]    req_valid;
  logic [NCLIENT*CW-1:0] req_code;
  logic [NCLIENT-1:0]    req_acpt;
  logic [NCLIENT-1:0]    cl_ack;
  logic [CW-1:0]         ackcode;
  logic [NCLIENT*DW-1:0] cl_txsrc;
  logic [DW-1:0]         tx_dst;
  logic                  tx_busy;
  logic                  up_request;
  logic                  clientack;
  logic [AW:0]           reqcnt;
  logic                  full;
  logic [NCLIENT-1:0]    overflow;

  modport master (
    output req_valid, req_code, cl_txsrc, tx_busy,
    input  req_acpt, cl_ack, ackcode, tx_dst, up_request, clientack, reqcnt, full, overflow
  );

  modport slave (
    input  req_valid, req_code, cl_txsrc, tx_busy,
    output req_acpt, cl_ack, ackcode, tx_dst, up_request, clientack, reqcnt, full, overflow
  );
endinterface
`default_nettype wire

// File: rtl/txreq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : txreq_fifo
// Purpose  : Single-clock FIFO with occupancy count and synchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module txreq_fifo #(
  parameter int AW = 5,
  parameter int W  = 18
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          wr_en_i,
  input  wire logic [W-1:0]  wr_data_i,
  input  wire logic          rd_en_i,
  output logic [W-1:0]       rd_data_o,
  output logic [AW:0]        count_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          w_wr;
  logic          w_rd;

  assign w_wr = wr_en_i & ~full_o;
  assign w_rd = rd_en_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w_wr) wptr_q <= wptr_q + 1'b1;
      if (w_rd) rptr_q <= rptr_q + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;
  // Count never exceeds DEPTH, so the MSB alone marks full.
  assign full_o    = cnt_q[AW];
  assign empty_o   = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/txreq_arbsw.sv
`default_nettype none
// ============================================================================
// Module   : txreq_arbsw
// Purpose  : N-client tx-request switch: pending capture, arbitration, queue, paced serve.
// Revision : 1.0 - initial release
// ============================================================================
module txreq_arbsw
  import txsw_pkg::*;
#(
  parameter int NCLIENT = 4,
  parameter int CW      = 16,
  parameter int DW      = 8,
  parameter int AW      = 5,
  parameter int RR      = 0,
  parameter int MINGAP  = 2
) (
  input wire logic      clk,
  input wire logic      rst,
  txreq_arbsw_if.slave  bus
);
  localparam int IW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [CW-1:0] code;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [NCLIENT-1:0]     pend_q, pend_d;
  logic [NCLIENT-1:0]     ovf_q, ovf_d;
  logic [CW-1:0]          pcode_q [NCLIENT];
  logic [CW-1:0]          pcode_d [NCLIENT];
  logic [2:0]             ptr_q, ptr_d;

  logic [MAX_CLIENTS-1:0] w_elig;
  int                     w_win;
  logic [NCLIENT-1:0]     w_grant;
  logic [IW-1:0]          w_gidx;
  logic [CW-1:0]          w_gcode;
  entry_t                 w_wr_ent;
  entry_t                 w_rd_ent;
  logic [EW-1:0]          w_rd_raw;
  logic [AW:0]            w_cnt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;

  srv_state_e             state_q, state_d;
  logic [3:0]             gap_q, gap_d;
  logic [IW-1:0]          sel_q, sel_d;
  logic [CW-1:0]          ackcode_q, ackcode_d;
  logic [NCLIENT-1:0]     clack_q, clack_d;
  logic                   clientack_q, clientack_d;
  logic                   served_q, served_d;
  logic [DW-1:0]          w_tx;

  // Arbitration: fixed priority is a round-robin scan that always starts at 0.
  always_comb begin
    w_elig = '0;
    w_elig[NCLIENT-1:0] = bus.req_valid | pend_q;
    w_win  = rr_pick(w_elig, (RR != 0) ? int'(ptr_q) : 0, NCLIENT);
    w_grant = '0;
    w_gidx  = '0;
    w_gcode = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (!w_full && w_win == i) begin
        w_grant[i] = 1'b1;
        w_gidx     = IW'(i);
        w_gcode    = bus.req_valid[i] ? bus.req_code[i*CW +: CW] : pcode_q[i];
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    pcode_d = pcode_q;
    ptr_d   = ptr_q;
    for (int i = 0; i < NCLIENT; i++) begin
      if (w_grant[i]) begin
        pend_d[i] = 1'b0;
      end else if (bus.req_valid[i]) begin
        pend_d[i]  = 1'b1;
        pcode_d[i] = bus.req_code[i*CW +: CW];
        if (pend_q[i]) ovf_d[i] = 1'b1;
      end
    end
    if (|w_grant) begin
      ptr_d = (int'(w_gidx) == NCLIENT - 1) ? 3'd0 : 3'(int'(w_gidx) + 1);
    end
  end

  assign w_wr_ent = '{idx: w_gidx, code: w_gcode};
  assign w_rd_ent = entry_t'(w_rd_raw);

  txreq_fifo #(.AW(AW), .W(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (|w_grant),
    .wr_data_i (w_wr_ent),
    .rd_en_i   (w_pop),
    .rd_data_o (w_rd_raw),
    .count_o   (w_cnt),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  // Serve FSM: pop from IDLE, one-cycle registered ack, then a paced gap.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    sel_d       = sel_q;
    ackcode_d   = ackcode_q;
    clack_d     = '0;
    clientack_d = 1'b0;
    served_d    = served_q;
    w_pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty && !bus.tx_busy) begin
          w_pop                 = 1'b1;
          sel_d                 = w_rd_ent.idx;
          ackcode_d             = w_rd_ent.code;
          clack_d[w_rd_ent.idx] = 1'b1;
          clientack_d           = 1'b1;
          served_d              = 1'b1;
          state_d               = ST_ACK;
        end
      end
      ST_ACK: begin
        gap_d   = 4'(MINGAP - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          if (!bus.tx_busy) state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      sel_q       <= '0;
      ackcode_q   <= '0;
      clack_q     <= '0;
      clientack_q <= 1'b0;
      served_q    <= 1'b0;
      for (int i = 0; i < NCLIENT; i++) pcode_q[i] <= '0;
    end else begin
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      gap_q       <= gap_d;
      sel_q       <= sel_d;
      ackcode_q   <= ackcode_d;
      clack_q     <= clack_d;
      clientack_q <= clientack_d;
      served_q    <= served_d;
      pcode_q     <= pcode_d;
    end
  end

  // tx data stays at zero after reset until the first entry has been served.
  always_comb begin
    w_tx = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      if (served_q && sel_q == IW'(i)) w_tx = bus.cl_txsrc[i*DW +: DW];
    end
  end

  assign bus.req_acpt   = w_grant;
  assign bus.up_request = |w_grant;
  assign bus.cl_ack     = clack_q;
  assign bus.clientack  = clientack_q;
  assign bus.ackcode    = ackcode_q;
  assign bus.tx_dst     = w_tx;
  assign bus.reqcnt     = w_cnt;
  assign bus.full       = w_full;
  assign bus.overflow   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_txreq_arbsw.sv
`default_nettype none
// ============================================================================
// Module   : tb_txreq_arbsw
// Purpose  : Random-stimulus scoreboard bench; fixed-priority and round-robin instances.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_txreq_arbsw;
  localparam int NC     = 4;
  localparam int CW     = 16;
  localparam int DW     = 8;
  localparam int AW     = 3;
  localparam int DEPTH  = 2 ** AW;
  localparam int MINGAP = 2;

  typedef struct {
    int idx;
    int code;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [NC-1:0]    s_valid = '0;
  logic [NC*CW-1:0] s_code  = '0;
  logic [NC*DW-1:0] s_src   = '0;
  logic             s_busy  = 1'b0;
  wire  [1:0]       ackv;

  task automatic chk(input string nm, input int unit, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s unit%0d cycle %0d: got 0x%0h expected 0x%0h", nm, unit, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    txreq_arbsw_if #(.NCLIENT(NC), .CW(CW), .DW(DW), .AW(AW)) bus ();

    assign bus.req_valid = s_valid;
    assign bus.req_code  = s_code;
    assign bus.cl_txsrc  = s_src;
    assign bus.tx_busy   = s_busy;
    assign ackv[g]       = bus.clientack;

    txreq_arbsw #(.NCLIENT(NC), .CW(CW), .DW(DW), .AW(AW), .RR(g), .MINGAP(MINGAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Reference model state: queue contents, pending table and serve timeline.
    ent_t    mfifo[$];
    ent_t    exp_q[$];
    bit [NC-1:0] mpend;
    bit [NC-1:0] movf;
    int      mpcode [NC];
    int      mptr, msel, mcode;
    bit      mserved;
    int      ack_at, last_ack, gap_exit;

    always @(negedge clk) begin : model
      int   win;
      bit   idle, pop;
      ent_t e;
      if (rst) begin
        mfifo.delete();
        exp_q.delete();
        mpend = '0; movf = '0; mptr = 0; msel = 0; mcode = 0; mserved = 0;
        ack_at = -1; last_ack = -1; gap_exit = -1;
        for (int i = 0; i < NC; i++) mpcode[i] = 0;
      end else begin
        win = -1;
        if (mfifo.size() < DEPTH) begin
          for (int k = 0; k < NC; k++) begin
            int i;
            i = (g == 1) ? (mptr + k) % NC : k;
            if (win < 0 && (s_valid[i] || mpend[i])) win = i;
          end
        end
        chk("req_acpt", g, bus.req_acpt, (win >= 0) ? (64'd1 << win) : 64'd0);
        chk("up_request", g, bus.up_request, win >= 0);
        chk("reqcnt", g, bus.reqcnt, mfifo.size());
        chk("full", g, bus.full, mfifo.size() == DEPTH);
        chk("overflow", g, bus.overflow, movf);
        chk("clientack", g, bus.clientack, cyc == ack_at);
        chk("ackcode_hold", g, bus.ackcode, mcode);
        chk("tx_dst", g, bus.tx_dst, mserved ? s_src[msel*DW +: DW] : '0);

        idle = (ack_at < cyc) && (last_ack < 0 || (gap_exit >= 0 && gap_exit < cyc));
        pop  = idle && mfifo.size() > 0 && !s_busy;

        if (win >= 0) begin
          e.idx  = win;
          e.code = s_valid[win] ? int'(s_code[win*CW +: CW]) : mpcode[win];
          mfifo.push_back(e);
          exp_q.push_back(e);
          if (g == 1) mptr = (win + 1) % NC;
        end
        for (int i = 0; i < NC; i++) begin
          if (i == win) mpend[i] = 1'b0;
          else if (s_valid[i]) begin
            if (mpend[i]) movf[i] = 1'b1;
            mpend[i]  = 1'b1;
            mpcode[i] = int'(s_code[i*CW +: CW]);
          end
        end

        if (cyc == ack_at) last_ack = cyc;
        if (gap_exit < 0 && last_ack >= 0 && ack_at == last_ack &&
            cyc >= last_ack + MINGAP && !s_busy) gap_exit = cyc;
        if (pop) begin
          e       = mfifo.pop_front();
          msel    = e.idx;
          mcode   = e.code;
          mserved = 1'b1;
          ack_at  = cyc + 1;
          gap_exit = -1;
        end
      end
    end

    // Scoreboard monitor: each ack must match the oldest granted request.
    always @(negedge clk) begin : monitor
      ent_t e;
      if (!rst && bus.clientack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", g, bus.clientack, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("cl_ack", g, bus.cl_ack, 64'd1 << e.idx);
          chk("ackcode", g, bus.ackcode, e.code);
          chk("tx_dst_at_ack", g, bus.tx_dst, s_src[e.idx*DW +: DW]);
        end
      end
    end
  end

  task automatic drive(input int preq, input int pbusy);
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) begin
      s_valid[i]          = ($urandom_range(99) < preq);
      s_code[i*CW +: CW]  = 16'($urandom);
    end
    s_src  = 32'($urandom);
    s_busy = ($urandom_range(99) < pbusy);
  endtask

  typedef struct {
    int preq;
    int pbusy;
    int ncyc;
  } phase_t;

  phase_t phases[5] = '{'{40, 0, 200}, '{90, 10, 300}, '{10, 50, 300}, '{0, 0, 80}, '{70, 30, 300}};

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request from client 2 into an idle switch.
    drive(0, 0);
    @(posedge clk); #1;
    s_valid = 4'b0100;
    s_code[2*CW +: CW] = 16'h0800;
    @(posedge clk); #1;
    s_valid = '0;
    repeat (8) drive(0, 0);

    foreach (phases[p]) begin
      for (int c = 0; c < phases[p].ncyc; c++) drive(phases[p].preq, phases[p].pbusy);
    end

    // Reset while unit 0 is presenting an ack with a loaded queue.
    repeat (30) drive(90, 0);
    t = 0;
    while (!ackv[0] && t < 50) begin
      drive(90, 0);
      t++;
    end
    chk("ack_before_reset", 0, ackv[0], 1'b1);
    s_valid = '0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) drive(0, 0);

    repeat (200) drive(60, 20);
    repeat (120) drive(0, 0);
    chk("drained_unit0", 0, g_cfg[0].exp_q.size(), 0);
    chk("drained_unit1", 1, g_cfg[1].exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
